// File: rtl/vga_pkg.sv
// Shared character codes, typewriter state encoding and glyph helpers
// for the text-mode video blocks.
package vga_pkg;

  localparam logic [6:0] CH_SPACE      = 7'h20;
  localparam logic [6:0] CH_A          = 7'h41;
  localparam logic [6:0] CH_Z          = 7'h5A;
  localparam logic [6:0] CH_UNDERSCORE = 7'h5F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REVEAL = 2'd1,
    ST_SHOWN  = 2'd2
  } tw_state_e;

  // Letter A..Z selected by n modulo 26, counting forwards from A.
  function automatic logic [6:0] letter_fwd(input int unsigned n);
    return CH_A + 7'(n % 32'd26);
  endfunction

  // Letter Z..A selected by n modulo 26, counting backwards from Z.
  function automatic logic [6:0] letter_back(input int unsigned n);
    return CH_Z - 7'(n % 32'd26);
  endfunction

endpackage

// File: rtl/game_text_rom.sv
// Combinational page text store: (page, row, col) -> 7-bit character code.
// Pages without defined text read back as SPACE.
module game_text_rom
  import vga_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int ROWS  = 8,
  parameter int PAGES = 4
) (
  input  logic [$clog2(PAGES)-1:0] page,
  input  logic [$clog2(ROWS)-1:0]  row,
  input  logic [$clog2(COLS)-1:0]  col,
  output logic [6:0]               code
);

  localparam int unsigned COLS_U = COLS;
  localparam int          CLW    = $clog2(COLS);

  int unsigned idx_s;

  assign idx_s = 32'(row) * COLS_U + 32'(col);

  // Page 0 runs A..Z forwards, page 1 Z..A backwards, page 2 is a
  // diagonal pattern with a blank left margin column.
  always_comb begin
    code = CH_SPACE;
    case (32'(page))
      32'd0: code = letter_fwd(idx_s);
      32'd1: code = letter_back(idx_s);
      32'd2: begin
        if (col == {CLW{1'b0}}) begin
          code = CH_SPACE;
        end else begin
          code = letter_fwd(32'(row) * 32'd3 + 32'(col));
        end
      end
      default: code = CH_SPACE;
    endcase
  end

endmodule

// File: rtl/game_text_typewriter.sv
// Typewriter-style text reveal: characters of a stored page appear one by
// one on frame ticks, with a blinking underscore cursor at the next cell.
module game_text_typewriter
  import vga_pkg::*;
#(
  parameter int COLS           = 16,
  parameter int ROWS           = 8,
  parameter int PAGES          = 4,
  parameter int TICKS_PER_CHAR = 2,
  parameter int BLINK_TICKS    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [$clog2(PAGES)-1:0]              page_sel,
  input  logic                                  frame_tick,
  input  logic                                  skip,
  input  logic [$clog2(ROWS)+$clog2(COLS)-1:0]  char_xy,
  output logic [6:0]                            char_code,
  output logic                                  busy,
  output logic                                  done
);

  localparam int          PW     = $clog2(PAGES);
  localparam int          CLW    = $clog2(COLS);
  localparam int          RW     = $clog2(ROWS);
  localparam int          XYW    = RW + CLW;
  localparam int          NCELLS = ROWS * COLS;
  localparam int          CW     = $clog2(NCELLS + 1);
  localparam int          TW     = (TICKS_PER_CHAR > 1) ? $clog2(TICKS_PER_CHAR) : 1;
  localparam int          BW     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned ROWS_U = ROWS;

  localparam logic [CW-1:0] CNT_FULL   = CW'(NCELLS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_CHAR - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  tw_state_e     state_r, state_nxt_s;
  logic [CW-1:0] reveal_cnt_r, reveal_cnt_nxt_s;
  logic [TW-1:0] tick_cnt_r, tick_cnt_nxt_s;
  logic [BW-1:0] blink_cnt_r, blink_cnt_nxt_s;
  logic          blink_r, blink_nxt_s;
  logic [PW-1:0] page_r, page_nxt_s;

  logic [CLW-1:0] col_s;
  logic [RW-1:0]  row_s;
  int unsigned    idx_s;
  int unsigned    cnt_s;
  logic [6:0]     rom_code_s;
  logic [6:0]     cell_s;

  assign col_s = char_xy[CLW-1:0];
  assign row_s = char_xy[XYW-1:CLW];
  assign idx_s = 32'({row_s, col_s});
  assign cnt_s = 32'(reveal_cnt_r);

  game_text_rom #(
    .COLS (COLS),
    .ROWS (ROWS),
    .PAGES(PAGES)
  ) u_rom (
    .page(page_r),
    .row (row_s),
    .col (col_s),
    .code(rom_code_s)
  );

  // Next-state logic: start overrides everything, skip overrides frame_tick.
  always_comb begin
    state_nxt_s      = state_r;
    reveal_cnt_nxt_s = reveal_cnt_r;
    tick_cnt_nxt_s   = tick_cnt_r;
    blink_cnt_nxt_s  = blink_cnt_r;
    blink_nxt_s      = blink_r;
    page_nxt_s       = page_r;
    if (start) begin
      state_nxt_s      = ST_REVEAL;
      page_nxt_s       = page_sel;
      reveal_cnt_nxt_s = {CW{1'b0}};
      tick_cnt_nxt_s   = {TW{1'b0}};
      blink_cnt_nxt_s  = {BW{1'b0}};
      blink_nxt_s      = 1'b1;
    end else begin
      case (state_r)
        ST_REVEAL: begin
          if (skip) begin
            state_nxt_s      = ST_SHOWN;
            reveal_cnt_nxt_s = CNT_FULL;
          end else if (frame_tick) begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_nxt_s = {TW{1'b0}};
              // Saturate at the full page and finish on the last character.
              if (reveal_cnt_r < CNT_FULL - CW'(1)) begin
                reveal_cnt_nxt_s = reveal_cnt_r + CW'(1);
              end else begin
                reveal_cnt_nxt_s = CNT_FULL;
                state_nxt_s      = ST_SHOWN;
              end
            end else begin
              tick_cnt_nxt_s = tick_cnt_r + TW'(1);
            end
            if (blink_cnt_r == BLINK_LAST) begin
              blink_cnt_nxt_s = {BW{1'b0}};
              blink_nxt_s     = ~blink_r;
            end else begin
              blink_cnt_nxt_s = blink_cnt_r + BW'(1);
            end
          end else begin
            state_nxt_s = ST_REVEAL;
          end
        end
        ST_IDLE:  state_nxt_s = ST_IDLE;
        ST_SHOWN: state_nxt_s = ST_SHOWN;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Visibility of the addressed cell, judged against the current state.
  always_comb begin
    cell_s = CH_SPACE;
    if (state_r == ST_IDLE || 32'(row_s) >= ROWS_U) begin
      cell_s = CH_SPACE;
    end else if (idx_s < cnt_s) begin
      cell_s = rom_code_s;
    end else if (state_r == ST_REVEAL && idx_s == cnt_s && blink_r) begin
      cell_s = CH_UNDERSCORE;
    end else begin
      cell_s = CH_SPACE;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      reveal_cnt_r <= {CW{1'b0}};
      tick_cnt_r   <= {TW{1'b0}};
      blink_cnt_r  <= {BW{1'b0}};
      blink_r      <= 1'b1;
      page_r       <= {PW{1'b0}};
      char_code    <= CH_SPACE;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      reveal_cnt_r <= reveal_cnt_nxt_s;
      tick_cnt_r   <= tick_cnt_nxt_s;
      blink_cnt_r  <= blink_cnt_nxt_s;
      blink_r      <= blink_nxt_s;
      page_r       <= page_nxt_s;
      char_code    <= cell_s;
      busy         <= (state_nxt_s == ST_REVEAL);
      done         <= (state_nxt_s == ST_SHOWN);
    end
  end

endmodule

// File: tb/tb_game_text_typewriter.sv
// Randomized bench for game_text_typewriter against a frame-count model
// of the reveal, plus fixed expectations for the documented scenarios.
module tb_game_text_typewriter;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int TPC  = 2;
  localparam int BT   = 16;
  localparam int NC   = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] page_sel = 2'd0;
  logic       frame_tick = 1'b0;
  logic       skip = 1'b0;
  logic [6:0] char_xy = 7'd0;
  logic [6:0] char_code;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  game_text_typewriter #(
    .COLS(16), .ROWS(8), .PAGES(4), .TICKS_PER_CHAR(2), .BLINK_TICKS(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .page_sel(page_sel),
    .frame_tick(frame_tick), .skip(skip), .char_xy(char_xy),
    .char_code(char_code), .busy(busy), .done(done)
  );

  int n_err = 0;
  int n_checks = 0;

  // Model: mode 0 idle, 1 revealing, 2 shown; visible count derives from frames.
  int m_mode = 0, m_rev = 0, m_frames = 0, m_page = 0;

  logic [6:0] pend_code = 7'h20, exp_code = 7'h20;
  bit pend_busy = 0, pend_done = 0, exp_busy = 0, exp_done = 0, chk_en = 0;

  function automatic logic [6:0] glyph(int p, int r, int c);
    int idx;
    idx = r * COLS + c;
    case (p)
      0: return 7'h41 + 7'(idx % 26);
      1: return 7'h5A - 7'(idx % 26);
      2: return (c == 0) ? 7'h20 : 7'h41 + 7'((r * 3 + c) % 26);
      default: return 7'h20;
    endcase
  endfunction

  function automatic logic [6:0] model_cell(logic [6:0] xy);
    int r, c, idx;
    bit ph;
    r = int'(xy) / COLS;
    c = int'(xy) % COLS;
    idx = r * COLS + c;
    ph = ((m_frames / BT) % 2) == 0;
    if (m_mode == 0 || r >= ROWS) return 7'h20;
    if (idx < m_rev) return glyph(m_page, r, c);
    if (m_mode == 1 && idx == m_rev && ph) return 7'h5F;
    return 7'h20;
  endfunction

  function automatic void model_update(bit st, logic [1:0] ps, bit ft, bit sk);
    if (st) begin
      m_mode = 1; m_page = int'(ps); m_frames = 0; m_rev = 0;
    end else if (m_mode == 1) begin
      if (sk) begin
        m_mode = 2; m_rev = NC;
      end else if (ft) begin
        m_frames++;
        m_rev = m_frames / TPC;
        if (m_rev >= NC) begin
          m_rev = NC; m_mode = 2;
        end
      end
    end
  endfunction

  task automatic chk(string name, int act, int expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("char_code", int'(char_code), int'(exp_code));
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
    end
  end

  // One clock: new inputs go in just after the edge and are sampled at the next.
  task automatic step(bit r, bit st, logic [1:0] ps, bit ft, bit sk, logic [6:0] xy);
    @(posedge clk);
    #1;
    rst = r; start = st; page_sel = ps; frame_tick = ft; skip = sk; char_xy = xy;
    exp_code = pend_code; exp_busy = pend_busy; exp_done = pend_done;
    if (r) begin
      m_mode = 0; m_rev = 0; m_frames = 0; m_page = 0;
      exp_code = 7'h20; exp_busy = 0; exp_done = 0;
      pend_code = 7'h20; pend_busy = 0; pend_done = 0;
    end else begin
      pend_code = model_cell(xy);
      model_update(st, ps, ft, sk);
      pend_busy = (m_mode == 1);
      pend_done = (m_mode == 2);
    end
    chk_en = 1;
  endtask

  task automatic peek(logic [6:0] xy, logic [6:0] lit, string name);
    step(0, 0, 2'd0, 0, 0, xy);
    step(0, 0, 2'd0, 0, 0, xy);
    chk(name, int'(char_code), int'(lit));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'($urandom_range(0, 3)), 1, 0, 7'($urandom_range(0, 127)));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) step(1, 0, 2'd0, 0, 0, 7'd0);
    for (int i = 0; i < NC; i++) step(0, 0, 2'd0, 0, 0, 7'(i));
    peek(7'd77, 7'h20, "idle_cell");
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);

    // Page 0, six ticks: three glyphs then the cursor.
    step(0, 1, 2'd0, 0, 0, 7'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 2'd3, 1, 0, 7'(i));
    peek(7'd0, 7'h41, "p0_idx0");
    peek(7'd1, 7'h42, "p0_idx1");
    peek(7'd2, 7'h43, "p0_idx2");
    peek(7'd3, 7'h5F, "p0_cursor");
    peek(7'd4, 7'h20, "p0_idx4");
    chk("p0_busy", int'(busy), 1);
    ticks(250);
    ticks(10);
    chk("p0_done", int'(done), 1);
    chk("p0_notbusy", int'(busy), 0);
    peek(7'd127, 7'h58, "p0_idx127");

    // Page 1 revealed by skip after three ticks.
    step(0, 1, 2'd1, 0, 0, 7'd0);
    ticks(3);
    step(0, 0, 2'd0, 0, 1, 7'd0);
    step(0, 0, 2'd0, 0, 0, 7'd0);
    chk("skip_done", int'(done), 1);
    for (int i = 0; i < NC; i++) step(0, 0, 2'($urandom_range(0, 3)), 0, 0, 7'(i));
    peek(7'd0, 7'h5A, "p1_idx0");
    peek(7'd27, 7'h59, "p1_idx27");

    // start+skip together: reveal restarts at zero; then abort by reset.
    step(0, 1, 2'd2, 1, 1, 7'd0);
    peek(7'd0, 7'h5F, "ss_cursor");
    chk("ss_busy", int'(busy), 1);
    ticks(80);
    peek(7'd40, 7'h20, "rev40_blink_off");
    peek(7'd39, 7'h4E, "p2_idx39");
    step(1, 0, 2'd0, 0, 0, 7'd0);
    step(1, 0, 2'd0, 0, 0, 7'd0);
    for (int i = 0; i < NC; i++) step(0, 0, 2'd0, 0, 0, 7'(i));
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // Cursor blink alternation.
    step(0, 1, 2'd0, 0, 0, 7'd0);
    ticks(16);
    peek(7'd8, 7'h20, "blink_off");
    ticks(16);
    peek(7'd16, 7'h5F, "blink_on");

    // Undefined page.
    step(0, 1, 2'd3, 0, 0, 7'd0);
    step(0, 0, 2'd0, 0, 1, 7'd0);
    peek(7'd5, 7'h20, "p3_blank");

    for (int i = 0; i < 3000; i++) begin
      bit r, st, ft, sk;
      r  = ($urandom_range(0, 399) == 0);
      st = ($urandom_range(0, 63) == 0);
      ft = ($urandom_range(0, 1) == 1);
      sk = ($urandom_range(0, 99) == 0);
      step(r, st, 2'($urandom_range(0, 3)), ft, sk, 7'($urandom_range(0, 127)));
    end
    step(0, 0, 2'd0, 0, 0, 7'd0);
    step(0, 0, 2'd0, 0, 0, 7'd0);
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/game_text_typewriter.md
GAME_TEXT_TYPEWRITER -- requirements
Module: game_text_typewriter

Interface
REQ-001 Parameter COLS, default 16: characters per text row (power of two).
REQ-002 Parameter ROWS, default 8: text rows per page.
REQ-003 Parameter PAGES, default 4: number of stored text pages.
REQ-004 Parameter TICKS_PER_CHAR, default 2: frame_tick pulses per revealed character (>=1).
REQ-005 Parameter BLINK_TICKS, default 16: frame_tick pulses per cursor blink half-period (>=1).
REQ-006 clk  in  1  system clock; one clock only.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  one-cycle pulse: latch page_sel, restart reveal.
REQ-009 page_sel  in  $clog2(PAGES)  page to display.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 skip  in  1  one-cycle pulse: reveal the whole page at once.
REQ-012 char_xy  in  $clog2(ROWS)+$clog2(COLS)  {row, col}, col in low bits.
REQ-013 char_code  out  7  character code for the addressed cell, registered.
REQ-014 busy  out  1  high while in REVEAL.
REQ-015 done  out  1  high while in SHOWN.

Function
REQ-016 FSM states: IDLE, REVEAL, SHOWN.
REQ-017 IDLE: every cell returns SPACE; busy=0, done=0.
REQ-018 start in any state -> REVEAL next cycle; page latched; reveal_cnt=0, tick_cnt=0, blink phase=1.
REQ-019 REVEAL: each frame_tick increments tick_cnt; at tick_cnt==TICKS_PER_CHAR-1 the tick_cnt wraps to 0 and reveal_cnt increments.
REQ-020 REVEAL -> SHOWN when reveal_cnt reaches ROWS*COLS; reveal_cnt saturates, never wraps.
REQ-021 skip in REVEAL -> SHOWN next cycle, reveal_cnt=ROWS*COLS; skip in IDLE/SHOWN ignored.
REQ-022 SHOWN holds until start or rst; frame_tick ignored.
REQ-023 Linear index idx = row*COLS+col; cell shows page glyph if idx<reveal_cnt.
REQ-024 Cursor: in REVEAL, cell idx==reveal_cnt returns UNDERSCORE when blink phase=1, else SPACE.
REQ-025 Blink phase toggles every BLINK_TICKS frame_ticks in REVEAL; own counter, independent of tick_cnt.
REQ-026 All other cells (idx>reveal_cnt, row>=ROWS) return SPACE.
REQ-027 Latency: char_code valid one clk after char_xy, using state/reveal_cnt sampled in the same cycle as char_xy.
REQ-028 Simultaneous: start beats skip and frame_tick same cycle (both ignored).
REQ-029 page_sel is sampled only on start; later changes have no effect.
REQ-030 Undefined page content returns SPACE.

Reset
REQ-031 rst asserted: state=IDLE, char_code=SPACE, busy=0, done=0, all counters 0, page=0, blink phase=1.
REQ-032 rst mid-REVEAL aborts immediately; no partial state survives.

Structure
REQ-033 Character constants (SPACE, A..Z, UNDERSCORE) and state enum live in vga_pkg.
REQ-034 Page text in sub-module game_text_rom: combinational (page, row, col) -> 7-bit code.
REQ-035 Top holds FSM, counters, visibility compare and the single output register.

Verification
REQ-036 rst, then read all cells -> every char_code=SPACE, busy=0, done=0.
REQ-037 start page 0, TICKS_PER_CHAR=2, issue 6 frame_ticks -> idx0..2 glyphs, idx3 UNDERSCORE, idx4+ SPACE, busy=1.
REQ-038 Continue ticks to 256 total -> done=1 after 128th char, busy=0; extra ticks change nothing.
REQ-039 start page 1, skip after 3 ticks -> next cycle done=1, all 128 cells equal page-1 ROM content.
REQ-040 start+skip same cycle -> REVEAL, reveal_cnt=0; rst at reveal_cnt=40 -> IDLE, all SPACE.
REQ-041 BLINK_TICKS=16 in REVEAL -> cursor cell alternates UNDERSCORE/SPACE every 16 frame_ticks.
